// File: rtl/sync_health_monitor.sv
// Link-health monitor: per-lock first-lock time, unlock/outage statistics,
// and block_id/frame_in_block continuity checking, all in the RX clock domain.

module sync_lock_track #(
  parameter int CNT_W = 32,
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stat_clr_i,
  input  logic             lock_i,
  input  logic [CNT_W-1:0] cyc_i,
  output logic             seen_o,
  output logic             active_o,
  output logic [CNT_W-1:0] first_o,
  output logic [CNT_W-1:0] unl_o,
  output logic [CNT_W-1:0] last_o,
  output logic [CNT_W-1:0] max_o,
  output logic [ACC_W-1:0] tot_o
);
  logic             lock_q, seen_q, seen_d, act_q, act_d;
  logic [CNT_W-1:0] first_q, first_d, unl_q, unl_d, out_q, out_d;
  logic [CNT_W-1:0] last_q, last_d, max_q, max_d;
  logic [ACC_W-1:0] tot_q, tot_d;
  logic [ACC_W:0]   tot_sum;
  logic             rise, fall;

  always_comb begin
    rise    = lock_i & ~lock_q;
    fall    = ~lock_i & lock_q;
    tot_sum = {1'b0, tot_q} + (ACC_W+1)'(out_q);
    seen_d  = seen_q;
    first_d = first_q;
    unl_d   = unl_q;
    act_d   = act_q;
    out_d   = out_q;
    last_d  = last_q;
    max_d   = max_q;
    tot_d   = tot_q;
    if (rise && !seen_q) begin
      seen_d  = 1'b1;
      first_d = cyc_i;
    end
    // A clear discards any outage in progress, so a coincident rise is not a recovery.
    if (stat_clr_i) begin
      unl_d  = '0;
      act_d  = 1'b0;
      out_d  = '0;
      last_d = '0;
      max_d  = '0;
      tot_d  = '0;
    end else if (act_q) begin
      if (rise) begin
        last_d = out_q;
        max_d  = (out_q > max_q) ? out_q : max_q;
        tot_d  = tot_sum[ACC_W] ? '1 : tot_sum[ACC_W-1:0];
        act_d  = 1'b0;
      end else begin
        out_d = (out_q == '1) ? out_q : out_q + 1'b1;
      end
    end
    if (fall && seen_q) begin
      unl_d = (unl_d == '1) ? unl_d : unl_d + 1'b1;
      act_d = 1'b1;
      out_d = CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q  <= 1'b0;
      seen_q  <= 1'b0;
      act_q   <= 1'b0;
      first_q <= '0;
      unl_q   <= '0;
      out_q   <= '0;
      last_q  <= '0;
      max_q   <= '0;
      tot_q   <= '0;
    end else begin
      lock_q  <= lock_i;
      seen_q  <= seen_d;
      act_q   <= act_d;
      first_q <= first_d;
      unl_q   <= unl_d;
      out_q   <= out_d;
      last_q  <= last_d;
      max_q   <= max_d;
      tot_q   <= tot_d;
    end
  end

  assign seen_o   = seen_q;
  assign active_o = act_q;
  assign first_o  = first_q;
  assign unl_o    = unl_q;
  assign last_o   = last_q;
  assign max_o    = max_q;
  assign tot_o    = tot_q;
endmodule

module sync_health_monitor #(
  parameter int NUM_LOCKS        = 2,
  parameter int FRAMES_PER_BLOCK = 255,
  parameter int BID_W            = 16,
  parameter int FIB_W            = 16,
  parameter int CNT_W            = 32,
  parameter int ACC_W            = 48,
  parameter int SEQ_LOCK_IDX     = 1,
  parameter int MAX_UNLOCKS      = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stat_clr,
  input  logic [NUM_LOCKS-1:0]       lock_in,
  input  logic                       frm_valid,
  input  logic [BID_W-1:0]           frm_block_id,
  input  logic [FIB_W-1:0]           frm_index,
  output logic [NUM_LOCKS*CNT_W-1:0] first_lock_cyc,
  output logic [NUM_LOCKS-1:0]       first_lock_seen,
  output logic [NUM_LOCKS*CNT_W-1:0] unlock_cnt,
  output logic [NUM_LOCKS-1:0]       unlock_active,
  output logic [NUM_LOCKS*CNT_W-1:0] rec_last,
  output logic [NUM_LOCKS*CNT_W-1:0] rec_max,
  output logic [NUM_LOCKS*ACC_W-1:0] rec_total,
  output logic                       seq_valid,
  output logic [CNT_W-1:0]           seq_err_cnt,
  output logic                       seq_err,
  output logic                       pass_flag
);
  localparam logic [FIB_W-1:0] FIB_LAST = FIB_W'(FRAMES_PER_BLOCK - 1);
  localparam logic [FIB_W:0]   FIB_LIM  = (FIB_W+1)'(FRAMES_PER_BLOCK);

  logic [CNT_W-1:0] cyc_q;
  logic [NUM_LOCKS-1:0][CNT_W-1:0] first_a, unl_a, last_a, max_a;
  logic [NUM_LOCKS-1:0][ACC_W-1:0] tot_a;

  always_ff @(posedge clk) begin
    if (rst) cyc_q <= '0;
    else     cyc_q <= (cyc_q == '1) ? cyc_q : cyc_q + 1'b1;
  end

  for (genvar i = 0; i < NUM_LOCKS; i++) begin : g_lock
    sync_lock_track #(.CNT_W(CNT_W), .ACC_W(ACC_W)) u_trk (
      .clk(clk), .rst(rst), .stat_clr_i(stat_clr), .lock_i(lock_in[i]), .cyc_i(cyc_q),
      .seen_o(first_lock_seen[i]), .active_o(unlock_active[i]), .first_o(first_a[i]),
      .unl_o(unl_a[i]), .last_o(last_a[i]), .max_o(max_a[i]), .tot_o(tot_a[i])
    );
  end

  assign first_lock_cyc = first_a;
  assign unlock_cnt     = unl_a;
  assign rec_last       = last_a;
  assign rec_max        = max_a;
  assign rec_total      = tot_a;

  logic             vld_q, vld_d, err_q, err_d, mism;
  logic [BID_W-1:0] bid_q, bid_d, exp_bid;
  logic [FIB_W-1:0] fib_q, fib_d, exp_fib;
  logic [CNT_W-1:0] ecnt_q, ecnt_d;

  always_comb begin
    exp_bid = (fib_q == FIB_LAST) ? bid_q + 1'b1 : bid_q;
    exp_fib = (fib_q == FIB_LAST) ? '0 : fib_q + 1'b1;
    mism    = ({1'b0, frm_index} >= FIB_LIM) || (frm_block_id != exp_bid) ||
              (frm_index != exp_fib);
    vld_d   = vld_q;
    bid_d   = bid_q;
    fib_d   = fib_q;
    ecnt_d  = ecnt_q;
    err_d   = 1'b0;
    if (stat_clr) begin
      vld_d  = 1'b0;
      ecnt_d = '0;
    end
    // Loss of the gating lock wins over a coincident frame.
    if (!lock_in[SEQ_LOCK_IDX]) begin
      vld_d = 1'b0;
    end else if (frm_valid) begin
      bid_d = frm_block_id;
      fib_d = frm_index;
      if (vld_d && mism) begin
        err_d  = 1'b1;
        ecnt_d = (ecnt_d == '1) ? ecnt_d : ecnt_d + 1'b1;
      end
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
      bid_q  <= '0;
      fib_q  <= '0;
      ecnt_q <= '0;
    end else begin
      vld_q  <= vld_d;
      err_q  <= err_d;
      bid_q  <= bid_d;
      fib_q  <= fib_d;
      ecnt_q <= ecnt_d;
    end
  end

  assign seq_valid   = vld_q;
  assign seq_err     = err_q;
  assign seq_err_cnt = ecnt_q;
  assign pass_flag   = (ecnt_q == '0) && (unl_a[0] <= CNT_W'(MAX_UNLOCKS));
endmodule
